// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  // One prefetch buffer entry: fetched instruction word and its PC.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  // RUN: fetching normally. TRAP: parked after a misaligned redirect.
  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer and occupancy tracking; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Head entry and empty flag for the consumer side.
  always_comb begin
    head  = mem[rd_ptr];
    empty = (count == '0);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word-aligned fetch, one-cycle memory
// latency absorbed by a credit-managed prefetch FIFO, valid/ready to decode,
// and redirect-driven flush/restart.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_en,
  output logic [XLEN-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic [INSTR_W-1:0]   instr_o,
  output logic [XLEN-1:0]      instr_pc_o,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  input  logic                 redirect_i,
  input  logic [XLEN-1:0]      redirect_pc_i,
  output logic                 misalign_o
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  fetch_state_t   state_q;
  fetch_state_t   state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            issue;
  logic            push;
  logic            pop;
  logic            trap;
  logic            fifo_empty;
  logic            fifo_flush;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM next state: only a redirect can move between RUN and TRAP.
  always_comb begin
    state_d = state_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (redirect_i) state_d = (redirect_pc_i[1:0] != 2'b00) ? TRAP : RUN;
`endif
  end

  // FSM outputs and handshake: issue only while a FIFO slot is guaranteed
  // for the response, counting the entry that leaves this cycle.
  always_comb begin
    trap          = (state_q == TRAP);
    instr_valid_o = reset && !fifo_empty && !redirect_i;
    pop           = instr_valid_o && instr_ready_i;
    credit_used   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight}
                  - {{CW{1'b0}}, pop};
    issue         = reset && !trap && !redirect_i && (credit_used < DEPTH_W);
    push          = reset && inflight && !redirect_i;
    fifo_flush    = redirect_i || trap;
    push_entry    = '{instr: imem_data, pc: inflight_pc};
    imem_en       = issue;
    imem_addr     = reset ? fetch_pc : RESET_PC;
    instr_o       = (reset && !fifo_empty) ? fifo_head.instr : '0;
    instr_pc_o    = (reset && !fifo_empty) ? fifo_head.pc : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_o    = reset && trap;
`else
    misalign_o    = 1'b0;
`endif
  end

  // Fetch PC and in-flight tracking; redirect wins over normal issue and
  // the low address bits are masked so fetch stays word aligned.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i & ~XLEN'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + XLEN'(4);
        inflight_pc <= fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset state, start-up latency, stall,
// redirect, PC wrap, misaligned redirect and mid-stream reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        misalign_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_pc   = '0;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data is a fixed function of the address.
  always @(posedge clk) begin
    if (imem_en) imem_data <= imem_addr ^ KEY;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs are driven here,
  // outputs are sampled one more time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready held high: every cycle must deliver the next sequential PC.
  task automatic stream(input int unsigned cycles);
    int unsigned seen = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      tick();
      #1;
      if (instr_valid_o && instr_ready_i) begin
        check("stream_pc", instr_pc_o, exp_pc);
        check("stream_instr", instr_o, exp_pc ^ KEY);
        exp_pc = exp_pc + 32'd4;
        seen++;
      end
    end
    check("stream_count", seen, cycles);
  endtask

  // Aligned redirect from a running stream: flush, refetch, first valid at R+3.
  task automatic redirect_to(input logic [31:0] target);
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    #1;
    check("redir_valid_R", instr_valid_o, 1'b0);
    check("redir_en_R", imem_en, 1'b0);
    tick();
    redirect_i = 1'b0;
    #1;
    check("redir_en_R1", imem_en, 1'b1);
    check("redir_addr_R1", imem_addr, target);
    check("redir_misalign_R1", misalign_o, 1'b0);
    check("redir_valid_R1", instr_valid_o, 1'b0);
    tick();
    #1;
    check("redir_valid_R2", instr_valid_o, 1'b0);
    check("redir_addr_R2", imem_addr, target + 32'd4);
    tick();
    #1;
    check("redir_valid_R3", instr_valid_o, 1'b1);
    check("redir_pc_R3", instr_pc_o, target);
    check("redir_instr_R3", instr_o, target ^ KEY);
    exp_pc = target + 32'd4;
  endtask

  initial begin
    // Reset held low.
    repeat (3) tick();
    #1;
    check("rst_en", imem_en, 1'b0);
    check("rst_valid", instr_valid_o, 1'b0);
    check("rst_misalign", misalign_o, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", instr_pc_o, 32'h0);

    // Release: cycle 0 issues RESET_PC immediately.
    tick();
    reset = 1'b1;
    #1;
    check("c0_en", imem_en, 1'b1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_valid", instr_valid_o, 1'b0);
    tick();
    #1;
    check("c1_en", imem_en, 1'b1);
    check("c1_addr", imem_addr, 32'h4);
    check("c1_valid", instr_valid_o, 1'b0);
    tick();
    #1;
    check("c2_valid", instr_valid_o, 1'b1);
    check("c2_pc", instr_pc_o, 32'h0);
    check("c2_instr", instr_o, 32'hA5A5_0000);
    check("c2_addr", imem_addr, 32'h8);
    exp_pc = 32'h4;
    stream(1);

    // Ready low for five cycles: buffer holds pc 8 and pc 12, issue stops.
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      instr_ready_i = 1'b0;
      #1;
      check("stall_en", imem_en, 1'b0);
      check("stall_valid", instr_valid_o, 1'b1);
      check("stall_pc", instr_pc_o, 32'h8);
    end
    tick();
    instr_ready_i = 1'b1;
    #1;
    check("resume_pc", instr_pc_o, 32'h8);
    check("resume_en", imem_en, 1'b1);
    check("resume_addr", imem_addr, 32'h10);
    exp_pc = 32'hC;
    stream(3);

    // Redirect with one buffered entry and one response in flight.
    redirect_to(32'h0000_1000);
    stream(3);

    // Address wrap at the top of the address space.
    redirect_to(32'hFFFF_FFF8);
    stream(3);

    // Misaligned redirect.
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_1002;
    #1;
    check("mis_en_R", imem_en, 1'b0);
    check("mis_valid_R", instr_valid_o, 1'b0);
    tick();
    redirect_i = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_flag_R1", misalign_o, 1'b1);
    check("mis_en_R1", imem_en, 1'b0);
    for (int unsigned i = 0; i < 2; i++) begin
      tick();
      #1;
      check("trap_flag", misalign_o, 1'b1);
      check("trap_en", imem_en, 1'b0);
      check("trap_valid", instr_valid_o, 1'b0);
    end
`else
    check("mis_flag_R1", misalign_o, 1'b0);
    check("mis_en_R1", imem_en, 1'b1);
    check("mis_addr_R1", imem_addr, 32'h0000_1000);
    tick();
    #1;
    tick();
    #1;
    check("mis_pc_R3", instr_pc_o, 32'h0000_1000);
    check("mis_instr_R3", instr_o, 32'h0000_1000 ^ KEY);
    exp_pc = 32'h0000_1004;
    stream(2);
`endif
    redirect_to(32'h0000_2000);
    stream(2);

    // One-cycle reset mid-stream.
    tick();
    reset = 1'b0;
    #1;
    check("mrst_en", imem_en, 1'b0);
    check("mrst_valid", instr_valid_o, 1'b0);
    check("mrst_addr", imem_addr, 32'h0);
    check("mrst_instr", instr_o, 32'h0);
    check("mrst_pc", instr_pc_o, 32'h0);
    check("mrst_misalign", misalign_o, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    check("mrst_c0_en", imem_en, 1'b1);
    check("mrst_c0_addr", imem_addr, 32'h0);
    check("mrst_c0_valid", instr_valid_o, 1'b0);
    tick();
    #1;
    check("mrst_c1_valid", instr_valid_o, 1'b0);
    tick();
    #1;
    check("mrst_c2_valid", instr_valid_o, 1'b1);
    check("mrst_c2_pc", instr_pc_o, 32'h0);
    check("mrst_c2_instr", instr_o, KEY);
    exp_pc = 32'h4;
    stream(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
